dsp_mac_sequencer: RTL and testbench
====================================

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 Parameter: CNT_W, default 8, width of the term-count field and counter.
REQ-002 Parameter: TIMEOUT, default 255, idle-input cycles tolerated in ACCUM (used only with the watchdog).
REQ-003 The block SHALL have these ports, clock and reset first (name, direction, width, meaning):
- CLK  in  1  single clock, all logic rising-edge.
- RST  in  1  reset, asynchronous and active-high.
- start  in  1  request a new dot product; sampled in IDLE only.
- len  in  CNT_W  number of A*B terms; sampled with start.
- in_valid  in  1  operand pair on A_in/B_in is valid.
- in_ready  out  1  sequencer accepts a pair this cycle.
- A_in, B_in  in  18 each  operand pair.
- dsp_A, dsp_B  out  18 each  to the DSP slice A/B; equal A_in/B_in combinationally.
- dsp_OPMODE  out  8  to the DSP slice OPMODE; the slice ties CEOPMODE=1.
- dsp_CEA, dsp_CEB, dsp_CEM, dsp_CEP  out  1 each  DSP clock enables.
- dsp_RSTP  out  1  DSP P-register reset (the slice uses RSTTYPE=SYNC).
- dsp_P  in  48  DSP P output.
- result  out  48  captured dot product.
- result_valid  out  1  result is held valid.
- result_ready  in  1  consumer accepts the result.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on a rejected start or a timeout.
REQ-004 The target slice is configured A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT", CARRYINSEL="OPMODE5".

Function
REQ-005 The FSM SHALL have the states IDLE, CLEAR, ACCUM, DRAIN and DONE.
REQ-006 IDLE: start=1 with len!=0 SHALL latch len, clear the accepted-term counter and go to CLEAR; start=1 with len==0 SHALL pulse err and stay in IDLE.
REQ-007 CLEAR lasts exactly 1 cycle with dsp_RSTP=1 and dsp_OPMODE=8'h09 (X=M, Z=P, add, carry-in 0, no pre-add), then goes to ACCUM.
REQ-008 dsp_OPMODE SHALL be 8'h09 in CLEAR, ACCUM and DRAIN, and 8'h00 in IDLE and DONE.
REQ-009 ACCUM: in_ready=1; a beat is accepted when in_valid&in_ready, and dsp_CEA=dsp_CEB=1 in that same cycle only.
REQ-010 For a beat accepted in cycle t: dsp_CEM=1 in cycle t+1 and dsp_CEP=1 in cycle t+2, driven from a 2-stage valid shift register; no other cycle asserts CEM or CEP.
REQ-011 When the counter reaches len on an accepted beat, the FSM SHALL go to DRAIN the next cycle with in_ready=0.
REQ-012 DRAIN lasts exactly 3 cycles; on its last cycle result<=dsp_P, and the FSM goes to DONE.
REQ-013 Latency: with the last beat accepted in cycle t, result_valid=1 from cycle t+4.
REQ-014 DONE: result_valid=1 and result stays stable until result_ready=1; the FSM then goes to IDLE, and result_valid falls the next cycle.
REQ-015 in_valid=0 during ACCUM stalls the sequence: no CEA/CEB, P holds, and pipelined CEM/CEP still complete.
REQ-016 start outside IDLE SHALL be ignored; in_valid outside ACCUM SHALL be ignored (in_ready=0).
REQ-017 The accumulator wraps modulo 2^48 with no saturation; result equals dsp_P as captured.

Reset
REQ-018 RST=1 SHALL asynchronously force IDLE, clear the counter, the shift register and result to 0, and drive every output low: in_ready, result_valid, busy, err, all CE, dsp_RSTP and dsp_OPMODE=8'h00.
REQ-019 RST=1 mid-operation SHALL abort the sequence; the next sequence's CLEAR state clears P.

Configuration
REQ-020 Macro DSP_MAC_TIMEOUT_EN, when defined: an idle counter increments each ACCUM cycle with in_valid=0, resets on an accepted beat, and on reaching TIMEOUT pulses err and returns to IDLE (result_valid stays 0).
REQ-021 When DSP_MAC_TIMEOUT_EN is undefined, no idle counter exists and ACCUM waits indefinitely.

Verification
REQ-022 len=3, pairs (2,3),(4,5),(1,1) back-to-back -> result=27, result_valid 4 cycles after the third accept.
REQ-023 Same as REQ-022 with in_valid low for 5 cycles between beats 1 and 2 -> result=27, CEM/CEP pulse count exactly 3 each.
REQ-024 start with len=0 -> err pulse 1 cycle, busy stays 0.
REQ-025 Two sequences (len=1, (7,7)) then (len=1, (1,2)), with result_ready held 1 -> results 49 then 2, showing P cleared between sequences.
REQ-026 RST asserted in ACCUM after 1 of 3 beats, then a new len=1 (3,3) sequence -> result=9.
REQ-027 With DSP_MAC_TIMEOUT_EN and TIMEOUT=4, len=2 with 1 beat then in_valid=0 -> err pulse after 4 idle cycles, FSM back in IDLE, result_valid never set.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: sequences a registered DSP multiply-accumulate slice through clear, accumulate and drain.
// Optional ACCUM watchdog enabled by defining DSP_MAC_TIMEOUT_EN.
module dsp_mac_sequencer #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      A_in,
    input  logic [17:0]      B_in,
    output logic [17:0]      dsp_A,
    output logic [17:0]      dsp_B,
    output logic [7:0]       dsp_OPMODE,
    output logic             dsp_CEA,
    output logic             dsp_CEB,
    output logic             dsp_CEM,
    output logic             dsp_CEP,
    output logic             dsp_RSTP,
    input  logic [47:0]      dsp_P,
    output logic [47:0]      result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy,
    output logic             err
);
    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       drain_cnt;
    logic [1:0]       vsr;
    logic             accept;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

`ifdef DSP_MAC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;
`endif

    assign accept  = in_valid & in_ready;
    assign dsp_A   = A_in;
    assign dsp_B   = B_in;
    assign dsp_CEA = accept;
    assign dsp_CEB = accept;
    // M stage one cycle after the operand registers, P stage one after that
    assign dsp_CEM = vsr[0];
    assign dsp_CEP = vsr[1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            len_q        <= '0;
            cnt          <= '0;
            drain_cnt    <= '0;
            vsr          <= '0;
            in_ready     <= 1'b0;
            dsp_OPMODE   <= 8'h00;
            dsp_RSTP     <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
`ifdef DSP_MAC_TIMEOUT_EN
            idle_cnt     <= '0;
`endif
        end else begin
            vsr      <= {vsr[0], accept};
            err      <= 1'b0;
            dsp_RSTP <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            err <= 1'b1;
                        end else begin
                            len_q      <= len;
                            cnt        <= '0;
                            state      <= CLEAR;
                            dsp_RSTP   <= 1'b1;
                            dsp_OPMODE <= 8'h09;
                            busy       <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    state    <= ACCUM;
                    in_ready <= 1'b1;
`ifdef DSP_MAC_TIMEOUT_EN
                    idle_cnt <= '0;
`endif
                end
                ACCUM: begin
                    if (accept) begin
                        cnt <= cnt + CNT_W'(1);
`ifdef DSP_MAC_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                        if (cnt + CNT_W'(1) == len_q) begin
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            drain_cnt <= '0;
                        end
                    end
`ifdef DSP_MAC_TIMEOUT_EN
                    else if (idle_cnt == TW'(TIMEOUT - 1)) begin
                        state      <= IDLE;
                        in_ready   <= 1'b0;
                        busy       <= 1'b0;
                        dsp_OPMODE <= 8'h00;
                        err        <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
`endif
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 2'd1;
                    // by the third drain cycle the final product has landed in P
                    if (drain_cnt == 2'd2) begin
                        result       <= dsp_P;
                        result_valid <= 1'b1;
                        dsp_OPMODE   <= 8'h00;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: randomized and directed checks of the MAC sequencer against a timeline model and a slice model.
module tb_dsp_mac_sequencer;
    localparam int CNT_W = 8;
    localparam int TO    = 4;
    localparam int INF   = 1 << 28;
`ifdef DSP_MAC_TIMEOUT_EN
    localparam int GAP = 3;
`else
    localparam int GAP = 5;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [17:0]      A_in = '0;
    logic [17:0]      B_in = '0;
    logic [17:0]      dsp_A, dsp_B;
    logic [7:0]       dsp_OPMODE;
    logic             dsp_CEA, dsp_CEB, dsp_CEM, dsp_CEP, dsp_RSTP;
    logic [47:0]      dsp_P = '0;
    logic [47:0]      result;
    logic             result_valid;
    logic             result_ready = 1'b0;
    logic             busy, err;

    always #5 CLK = ~CLK;

    dsp_mac_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .A_in(A_in), .B_in(B_in),
        .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_OPMODE(dsp_OPMODE),
        .dsp_CEA(dsp_CEA), .dsp_CEB(dsp_CEB), .dsp_CEM(dsp_CEM), .dsp_CEP(dsp_CEP),
        .dsp_RSTP(dsp_RSTP), .dsp_P(dsp_P), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy), .err(err)
    );

    // Slice model: A1/B1, M, P and OPMODE registers; P is untouched by the sequencer's reset
    logic signed [17:0] a_r = '0, b_r = '0;
    logic signed [35:0] m_r = '0;
    logic [7:0]         op_r = '0;
    always @(posedge CLK) begin
        if (dsp_CEA) a_r <= dsp_A;
        if (dsp_CEB) b_r <= dsp_B;
        if (dsp_CEM) m_r <= a_r * b_r;
        op_r <= dsp_OPMODE;
        if (dsp_RSTP) dsp_P <= '0;
        else if (dsp_CEP) dsp_P <= (op_r == 8'h09) ? dsp_P + 48'(m_r) : '0;
    end

    int errors = 0, checks = 0;
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Timeline model: start cycle ts, last accept tl, end of sequence te
    int cyc = 0;
    bit act = 0;
    int ts = 0, tl = INF, te = INF, terr = -1, mcnt = 0, mlen = 0, streak = 0;
    logic [47:0] msum = '0, mres = '0;
    bit h1 = 0, h2 = 0;
    int n_cem = 0, n_cep = 0;

    always @(negedge CLK) begin
        bit e_busy, e_rstp, e_rdy, e_rv, acc;
        logic [7:0] e_op;
        cyc++;
        if (RST) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_result_valid", result_valid, 0);
            chk("rst_err", err, 0);
            chk("rst_ce", {dsp_CEA, dsp_CEB, dsp_CEM, dsp_CEP, dsp_RSTP}, 0);
            chk("rst_opmode", dsp_OPMODE, 0);
            chk("rst_result", result, 0);
            act = 0; h1 = 0; h2 = 0; terr = -1;
        end else begin
            e_busy = act && cyc > ts && cyc <= te;
            e_rstp = act && cyc == ts + 1;
            e_op   = (act && cyc >= ts + 1 && cyc <= tl + 3 && cyc <= te) ? 8'h09 : 8'h00;
            e_rdy  = act && cyc >= ts + 2 && cyc <= tl && cyc <= te;
            e_rv   = act && cyc >= tl + 4 && cyc <= te;
            chk("busy", busy, e_busy);
            chk("rstp", dsp_RSTP, e_rstp);
            chk("opmode", dsp_OPMODE, e_op);
            chk("in_ready", in_ready, e_rdy);
            chk("result_valid", result_valid, e_rv);
            chk("err", err, cyc == terr);
            chk("cea", dsp_CEA, e_rdy && in_valid);
            chk("ceb", dsp_CEB, e_rdy && in_valid);
            chk("cem", dsp_CEM, h1);
            chk("cep", dsp_CEP, h2);
            chk("dsp_ab", {dsp_A, dsp_B}, {A_in, B_in});
            if (e_rv) chk("result", result, mres);
            n_cem += int'(dsp_CEM);
            n_cep += int'(dsp_CEP);
            acc = e_rdy && in_valid;
            h2 = h1;
            h1 = acc;
            if (acc) begin
                streak = 0;
                mcnt++;
                msum += 48'($signed(A_in) * $signed(B_in));
                if (mcnt == mlen) begin
                    tl = cyc;
                    mres = msum;
                end
            end else if (e_rdy) begin
                streak++;
`ifdef DSP_MAC_TIMEOUT_EN
                if (streak == TO) begin
                    te = cyc;
                    terr = cyc + 1;
                end
`endif
            end
            if (e_rv && result_ready) te = cyc;
            if ((!act || cyc > te) && start) begin
                if (len == '0) terr = cyc + 1;
                else begin
                    act = 1; ts = cyc; tl = INF; te = INF;
                    mcnt = 0; mlen = int'(len); msum = '0; streak = 0;
                end
            end
        end
    end

    logic [17:0] oa [16];
    logic [17:0] ob [16];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((busy || result_valid) && g < 100) begin
            tick();
            g++;
        end
        chk("wait_idle", 64'(g < 100), 1);
    endtask

    task automatic run_seq(input int n, input int gap, input bit rnd, input bit rr_hold,
                           output logic [47:0] res, output int lat);
        int i = 0, guard = 0, run = 0, gap_left = gap;
        bit rdy, go;
        wait_idle();
        start = 1'b1;
        len = CNT_W'(n);
        tick();
        start = 1'b0;
        while (i < n && guard < 500) begin
            rdy = in_ready;
            go = 1'b1;
            if (i == 1 && gap_left > 0 && rdy) begin
                go = 1'b0;
                gap_left--;
            end else if (rnd && rdy && run < 2 && $urandom_range(0, 2) == 0) go = 1'b0;
            run = (rdy && !go) ? run + 1 : 0;
            in_valid = go;
            A_in = go ? oa[i] : 18'($urandom);
            B_in = go ? ob[i] : 18'($urandom);
            start = rnd && $urandom_range(0, 3) == 0;
            len = CNT_W'($urandom_range(0, 3));
            tick();
            guard++;
            if (go && rdy) i++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        chk("beats_accepted", i, n);
        lat = 1;
        guard = 0;
        while (!result_valid && guard < 20) begin
            tick();
            lat++;
            guard++;
        end
        res = result;
        guard = 0;
        while ((busy || result_valid) && guard < 50) begin
            result_ready = rr_hold ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        chk("seq_retired", 64'(guard < 50), 1);
        if (!rr_hold) result_ready = 1'b0;
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!in_ready && g < 10) begin
            tick();
            g++;
        end
        chk("wait_ready", in_ready, 1);
    endtask

    initial begin
        logic [47:0] res, e;
        int lat, k, c0, p0, n;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_opmode", dsp_OPMODE, 0);

        oa[0] = 18'd2; ob[0] = 18'd3;
        oa[1] = 18'd4; ob[1] = 18'd5;
        oa[2] = 18'd1; ob[2] = 18'd1;
        run_seq(3, 0, 0, 1, res, lat);
        chk("dot3_result", res, 48'd27);
        chk("dot3_latency", lat, 4);

        c0 = n_cem;
        p0 = n_cep;
        run_seq(3, GAP, 0, 1, res, lat);
        chk("stall_result", res, 48'd27);
        chk("stall_latency", lat, 4);
        chk("stall_cem_pulses", n_cem - c0, 3);
        chk("stall_cep_pulses", n_cep - p0, 3);
        result_ready = 1'b0;

        wait_idle();
        start = 1'b1;
        len = '0;
        tick();
        start = 1'b0;
        chk("len0_err", err, 1);
        chk("len0_busy", busy, 0);
        tick();
        chk("len0_err_fall", err, 0);
        chk("len0_busy_after", busy, 0);

        result_ready = 1'b1;
        oa[0] = 18'd7; ob[0] = 18'd7;
        run_seq(1, 0, 0, 1, res, lat);
        chk("back2back_first", res, 48'd49);
        oa[0] = 18'd1; ob[0] = 18'd2;
        run_seq(1, 0, 0, 1, res, lat);
        chk("back2back_second", res, 48'd2);
        result_ready = 1'b0;

        wait_idle();
        start = 1'b1;
        len = CNT_W'(3);
        tick();
        start = 1'b0;
        wait_ready();
        in_valid = 1'b1;
        A_in = 18'd5;
        B_in = 18'd6;
        tick();
        in_valid = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        chk("abort_busy", busy, 0);
        tick();
        RST = 1'b0;
        oa[0] = 18'd3; ob[0] = 18'd3;
        run_seq(1, 0, 0, 1, res, lat);
        chk("after_abort_result", res, 48'd9);
        result_ready = 1'b0;

`ifdef DSP_MAC_TIMEOUT_EN
        wait_idle();
        start = 1'b1;
        len = CNT_W'(2);
        tick();
        start = 1'b0;
        wait_ready();
        in_valid = 1'b1;
        A_in = 18'd1;
        B_in = 18'd1;
        tick();
        in_valid = 1'b0;
        k = 1;
        while (!err && k < 20) begin
            tick();
            k++;
        end
        chk("timeout_delay", k, 5);
        chk("timeout_busy", busy, 0);
        chk("timeout_rv", result_valid, 0);
        repeat (6) tick();
        chk("timeout_rv_later", result_valid, 0);
`endif

        repeat (12) begin
            n = $urandom_range(1, 8);
            e = '0;
            for (int j = 0; j < n; j++) begin
                oa[j] = 18'($urandom);
                ob[j] = 18'($urandom);
                e += 48'($signed(oa[j]) * $signed(ob[j]));
            end
            run_seq(n, 0, 1, 1'($urandom_range(0, 1)), res, lat);
            chk("random_result", res, e);
        end
        result_ready = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "time limit");
    end
endmodule
